apb_completer_mem: RTL and testbench

// - APB3/APB4 completer that answers the team's APB master: a byte-addressable register/memory bank with programmable wait states.
// - Decodes PSTRB byte-enables, checks PPROT and address range, and reports failures on PSLVERR.
// - Sits on the peripheral side of the APB bus; one instance per PSELx line.

---
 rtl/apb_pkg.sv | 40 ++++
 rtl/apb_mem_bank.sv | 47 ++++
 rtl/apb_completer_mem.sv | 140 ++++++++++++++
 tb/tb_apb_completer_mem.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and helpers for the APB completer memory
// Holds the FSM state type, bus widths, the latched-request record and the
// byte-lane merge used by the storage bank.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = 4;

  typedef enum logic {
    APB_IDLE,
    APB_ACCESS
  } apb_cstate_e;

  // Request fields captured in the setup cycle and held through ACCESS.
  typedef struct packed {
    logic [APB_ADDR_W-1:0] addr;
    logic                  write;
    logic [APB_DATA_W-1:0] wdata;
    logic [APB_STRB_W-1:0] strb;
    logic [2:0]            prot;
  } apb_req_t;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [APB_DATA_W-1:0] apb_lane_merge(
    input logic [APB_DATA_W-1:0] old_word,
    input logic [APB_DATA_W-1:0] new_word,
    input logic [APB_STRB_W-1:0] strb
  );
    logic [APB_DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < APB_STRB_W; i++) begin
      if (strb[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/apb_mem_bank.sv
// rtl/apb_mem_bank.sv - word storage with byte-enable write and combinational read
// Ports:
//   clk, rst          clock, synchronous active-high clear of every word
//   we, waddr         write enable and word index
//   wstrb, wdata      byte-lane enables and write data
//   raddr, rdata      read word index and combinational read data
module apb_mem_bank
  import apb_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [APB_STRB_W-1:0] wstrb,
  input  logic [APB_DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [APB_DATA_W-1:0] rdata
);

  logic [APB_DATA_W-1:0] mem_q [DEPTH];
  logic [APB_DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we) begin
      mem_d[waddr] = apb_lane_merge(mem_q[waddr], wdata, wstrb);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        mem_q[i] <= '0;
      end else begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb_completer_mem.sv
// rtl/apb_completer_mem.sv - APB3/APB4 completer with byte-addressable memory and wait states
// Ports:
//   PCLK, PRESET        clock, synchronous active-high reset
//   PSELx, PENABLE      select and access-phase flag
//   PWRITE, PADDR       direction and byte address
//   PWDATA, PSTRB       write data and byte enables
//   PPROT               protection ([1] = non-secure)
//   cfg_wait            wait states per transfer, sampled in the setup cycle
//   PREADY, PRDATA      completion flag and read data
//   PSLVERR             error response, qualified by PREADY
module apb_completer_mem
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 64,
  parameter int SECURE_BASE = 32
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSELx,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [APB_STRB_W-1:0] PSTRB,
  input  logic [2:0]            PPROT,
  input  logic [3:0]            cfg_wait,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] SECURE_A = ADDR_WIDTH'(SECURE_BASE);

  apb_cstate_e           state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  apb_req_t              req_q, req_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  setup_err;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  ready_w;

  assign word_idx = PADDR >> 2;

  // Error decode is evaluated on the live bus during the setup cycle only.
  always_comb begin
    setup_err = (PADDR[1:0] != 2'b00)
              | (word_idx >= DEPTH_A)
              | (PPROT[1] & (word_idx >= SECURE_A))
              | (!PWRITE & (PSTRB != '0));
  end

  // Outputs come from registers only, so PREADY has no path from bus inputs.
  assign ready_w = (state_q == APB_ACCESS) && (cnt_q == 4'd0);
  assign PREADY  = ready_w;
  assign PSLVERR = ready_w & err_q;
  assign PRDATA  = (ready_w & !req_q.write & !err_q) ? rdata_q : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;

    unique case (state_q)
      APB_IDLE: begin
        // PSELx with PENABLE already high is not a valid setup; ignore it.
        if (PSELx && !PENABLE) begin
          state_d     = APB_ACCESS;
          req_d.addr  = APB_ADDR_W'(PADDR);
          req_d.write = PWRITE;
          req_d.wdata = PWDATA;
          req_d.strb  = PSTRB;
          req_d.prot  = PPROT;
          cnt_d       = cfg_wait;
          err_d       = setup_err;
          // Captured now so a write completed on the previous edge is seen.
          rdata_d     = mem_rdata;
        end
      end
      APB_ACCESS: begin
        if (!PSELx) begin
          state_d = APB_IDLE;
        end else if (PENABLE) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d = APB_IDLE;
            mem_we  = req_q.write & !err_q;
          end
        end
      end
      default: state_d = APB_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= APB_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
    end
  end

  apb_mem_bank #(
    .DEPTH (MEM_DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk   (PCLK),
    .rst   (PRESET),
    .we    (mem_we),
    .waddr (req_q.addr[IDX_W+1:2]),
    .wstrb (req_q.strb),
    .wdata (req_q.wdata),
    .raddr (word_idx[IDX_W-1:0]),
    .rdata (mem_rdata)
  );

  // Fields kept for completeness of the request record but not consumed.
  logic unused_bits;
  assign unused_bits = ^{req_q.prot, req_q.addr, PPROT[0], PPROT[2]};

endmodule

// File: tb/tb_apb_completer_mem.sv
// tb/tb_apb_completer_mem.sv - directed self-checking bench for apb_completer_mem
module tb_apb_completer_mem;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic [3:0]  cfg_wait;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd;
  logic        er;
  int          cyc;

  apb_completer_mem #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .MEM_DEPTH   (64),
    .SECURE_BASE (32)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .PSELx    (PSELx),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PSTRB    (PSTRB),
    .PPROT    (PPROT),
    .cfg_wait (cfg_wait),
    .PREADY   (PREADY),
    .PRDATA   (PRDATA),
    .PSLVERR  (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transfer; returns after sampling the completion cycle, so a
  // following call drives its setup in the very next cycle.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] strb, input logic [2:0] prot, input logic [3:0] wt,
                      output logic [31:0] rdo, output logic erro, output int cyco);
    @(negedge PCLK);
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr;
    PWDATA = wd; PSTRB = strb; PPROT = prot; cfg_wait = wt;
    @(negedge PCLK);
    PENABLE  = 1'b1;
    cfg_wait = 4'hF;  // must not affect the transfer in flight
    cyco = 2;
    while (PREADY !== 1'b1 && cyco < 40) begin
      @(negedge PCLK);
      cyco++;
    end
    rdo  = PRDATA;
    erro = PSLVERR;
  endtask

  task automatic idle();
    @(negedge PCLK);
    PSELx = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    PRESET = 1'b1; PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0; PPROT = '0; cfg_wait = '0;
    repeat (2) @(negedge PCLK);
    chk("rst_pready", {31'd0, PREADY}, 32'd0);
    chk("rst_prdata", PRDATA, 32'd0);
    chk("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
    PRESET = 1'b0;

    // Full-word write and readback, zero wait states.
    xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 4'd0, rd, er, cyc);
    chk("wr10_cycles", cyc, 32'd2);
    chk("wr10_err", {31'd0, er}, 32'd0);
    idle();
    xfer(1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 4'd0, rd, er, cyc);
    chk("rd10_cycles", cyc, 32'd2);
    chk("rd10_data", rd, 32'hDEADBEEF);
    chk("rd10_err", {31'd0, er}, 32'd0);
    idle();

    // Partial-lane write over an empty word.
    xfer(1'b1, 32'h20, 32'h11223344, 4'b0101, 3'b000, 4'd0, rd, er, cyc);
    idle();
    xfer(1'b0, 32'h20, 32'h0, 4'h0, 3'b000, 4'd0, rd, er, cyc);
    chk("rd20_strb", rd, 32'h00220044);
    idle();

    // Three wait states.
    xfer(1'b0, 32'h04, 32'h0, 4'h0, 3'b000, 4'd3, rd, er, cyc);
    chk("wait3_cycles", cyc, 32'd5);
    chk("wait3_data", rd, 32'h0);
    idle();

    // Error responses.
    xfer(1'b1, 32'h102, 32'hFFFFFFFF, 4'hF, 3'b000, 4'd0, rd, er, cyc);
    chk("err_misalign", {31'd0, er}, 32'd1);
    idle();
    xfer(1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 3'b000, 4'd1, rd, er, cyc);
    chk("err_range", {31'd0, er}, 32'd1);
    chk("err_range_cycles", cyc, 32'd3);
    idle();
    xfer(1'b0, 32'h10, 32'h0, 4'h1, 3'b000, 4'd0, rd, er, cyc);
    chk("err_rdstrb", {31'd0, er}, 32'd1);
    chk("err_rdstrb_data", rd, 32'h0);
    idle();
    xfer(1'b1, 32'hA0, 32'h12345678, 4'hF, 3'b010, 4'd0, rd, er, cyc);
    chk("err_secure", {31'd0, er}, 32'd1);
    idle();
    xfer(1'b0, 32'hA0, 32'h0, 4'h0, 3'b000, 4'd0, rd, er, cyc);
    chk("secure_unchanged", rd, 32'h0);
    chk("secure_rd_ok", {31'd0, er}, 32'd0);
    idle();
    xfer(1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 4'd0, rd, er, cyc);
    chk("rd10_after_errs", rd, 32'hDEADBEEF);
    idle();

    // Non-secure access just below the secure region is legal.
    xfer(1'b1, 32'h7C, 32'hCAFEF00D, 4'hF, 3'b010, 4'd0, rd, er, cyc);
    chk("ns_wr31_err", {31'd0, er}, 32'd0);
    idle();
    xfer(1'b0, 32'h7C, 32'h0, 4'h0, 3'b010, 4'd0, rd, er, cyc);
    chk("ns_rd31_data", rd, 32'hCAFEF00D);
    idle();

    // Back-to-back write then read with no idle cycle.
    xfer(1'b1, 32'h08, 32'hA5A5A5A5, 4'hF, 3'b000, 4'd0, rd, er, cyc);
    xfer(1'b0, 32'h08, 32'h0, 4'h0, 3'b000, 4'd0, rd, er, cyc);
    chk("b2b_data", rd, 32'hA5A5A5A5);
    chk("b2b_cycles", cyc, 32'd2);
    idle();

    // Zero-strobe write completes without touching memory.
    xfer(1'b1, 32'h10, 32'h00000000, 4'h0, 3'b000, 4'd0, rd, er, cyc);
    chk("strb0_err", {31'd0, er}, 32'd0);
    idle();
    xfer(1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 4'd0, rd, er, cyc);
    chk("strb0_unchanged", rd, 32'hDEADBEEF);
    idle();

    // PSELx dropped mid-transfer aborts with no write.
    @(negedge PCLK);
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h14;
    PWDATA = 32'h77777777; PSTRB = 4'hF; PPROT = 3'b000; cfg_wait = 4'd2;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSELx = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    chk("abort_pready", {31'd0, PREADY}, 32'd0);
    xfer(1'b0, 32'h14, 32'h0, 4'h0, 3'b000, 4'd0, rd, er, cyc);
    chk("abort_nowrite", rd, 32'h0);
    idle();

    // Reset during the second wait cycle of a write.
    @(negedge PCLK);
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0C;
    PWDATA = 32'h55555555; PSTRB = 4'hF; PPROT = 3'b000; cfg_wait = 4'd3;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b1;
    @(negedge PCLK);
    chk("midrst_pready", {31'd0, PREADY}, 32'd0);
    PRESET = 1'b0; PSELx = 1'b0; PENABLE = 1'b0;
    xfer(1'b0, 32'h0C, 32'h0, 4'h0, 3'b000, 4'd0, rd, er, cyc);
    chk("midrst_mem3", rd, 32'h0);
    chk("midrst_idle_ok", cyc, 32'd2);
    idle();
    xfer(1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 4'd0, rd, er, cyc);
    chk("midrst_mem_cleared", rd, 32'h0);
    idle();

    repeat (2) @(negedge PCLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
